// File: rtl/spi_pixel_rx_if.sv
// spi_pixel_rx_if: valid/ready pixel-write handshake between the SPI receiver and the framebuffer writer
interface spi_pixel_rx_if #(parameter int COLOR_W = 4);
  logic               wr_valid;
  logic               wr_ready;
  logic [7:0]         wr_x;
  logic [7:0]         wr_y;
  logic [COLOR_W-1:0] wr_color;
  logic               wr_clear;
  modport master (output wr_valid, wr_x, wr_y, wr_color, wr_clear, input wr_ready);
  modport slave (input wr_valid, wr_x, wr_y, wr_color, wr_clear, output wr_ready);
endinterface

// File: rtl/spi_pixel_rx.sv
// spi_pixel_rx: oversampled SPI mode-0 receiver of 3-byte draw packets (x, y, clear/colour) with range check.
// Define SPI_PKT_COUNT_EN to enable the accepted-packet counter on pkt_count.
module spi_pixel_rx #(
  parameter int X_MAX       = 160,
  parameter int Y_MAX       = 120,
  parameter int COLOR_W     = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk_hf,
  input  logic         reset,
  input  logic         sck,
  input  logic         sdi,
  input  logic         cs,
  spi_pixel_rx_if.master wr,
  output logic         err_range,
  output logic         err_overflow,
  output logic [15:0]  pkt_count
);
  typedef enum logic [1:0] {IDLE, BYTE_X, BYTE_Y, BYTE_C} state_t;
  localparam logic [8:0] XM = 9'(X_MAX);
  localparam logic [8:0] YM = 9'(Y_MAX);
  state_t                 state_q;
  logic [SYNC_STAGES-1:0] sck_sync_q, sdi_sync_q, cs_sync_q;
  logic                   sck_prev_q;
  logic [2:0]             bit_cnt_q;
  logic [6:0]             shift_q;
  logic [7:0]             x_q, y_q;
  logic                   sck_s, sdi_s, cs_s, rise, accept, busy, bad;
  logic [7:0]             byte_d;
  assign sck_s  = sck_sync_q[SYNC_STAGES-1];
  assign sdi_s  = sdi_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign rise   = sck_s & ~sck_prev_q;
  assign byte_d = {shift_q, sdi_s};
  assign accept = wr.wr_valid & wr.wr_ready;
  assign busy   = wr.wr_valid & ~wr.wr_ready;
  assign bad    = ~byte_d[7] & (({1'b0, x_q} >= XM) | ({1'b0, y_q} >= YM));
  // Completion loads after the accept clear so a same-cycle accept frees the slot for the new packet.
  always_ff @(posedge clk_hf) begin
    if (reset) begin
      sck_sync_q   <= '0;
      sdi_sync_q   <= '0;
      cs_sync_q    <= '0;
      sck_prev_q   <= 1'b0;
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      x_q          <= '0;
      y_q          <= '0;
      wr.wr_valid  <= 1'b0;
      wr.wr_x      <= '0;
      wr.wr_y      <= '0;
      wr.wr_color  <= '0;
      wr.wr_clear  <= 1'b0;
      err_range    <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], sck};
      sdi_sync_q <= {sdi_sync_q[SYNC_STAGES-2:0], sdi};
      cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0], cs};
      sck_prev_q <= sck_s;
      err_range  <= 1'b0;
      if (accept) wr.wr_valid <= 1'b0;
      if (!cs_s) begin
        state_q   <= IDLE;
        bit_cnt_q <= '0;
      end else if (state_q == IDLE) begin
        state_q <= BYTE_X;
      end else if (rise) begin
        shift_q   <= byte_d[6:0];
        bit_cnt_q <= bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          if (state_q == BYTE_X) begin
            x_q     <= byte_d;
            state_q <= BYTE_Y;
          end else if (state_q == BYTE_Y) begin
            y_q     <= byte_d;
            state_q <= BYTE_C;
          end else begin
            state_q <= BYTE_X;
            if (busy) err_overflow <= 1'b1;
            else if (bad) err_range <= 1'b1;
            else begin
              wr.wr_valid <= 1'b1;
              wr.wr_x     <= x_q;
              wr.wr_y     <= y_q;
              wr.wr_color <= byte_d[COLOR_W-1:0];
              wr.wr_clear <= byte_d[7];
            end
          end
        end
      end
    end
  end
`ifdef SPI_PKT_COUNT_EN
  logic [15:0] pkt_count_q;
  always_ff @(posedge clk_hf) pkt_count_q <= reset ? '0 : pkt_count_q + 16'(accept);
  assign pkt_count = pkt_count_q;
`else
  assign pkt_count = '0;
`endif
endmodule

// File: tb/tb_spi_pixel_rx.sv
// tb_spi_pixel_rx: directed packet sequence against spi_pixel_rx with immediate-assertion checks
module tb_spi_pixel_rx;
`ifdef SPI_PKT_COUNT_EN
  localparam int PKT_EN = 1;
`else
  localparam int PKT_EN = 0;
`endif
  logic clk = 0, reset = 1, sck = 0, sdi = 0, cs = 0;
  logic err_range, err_overflow;
  logic [15:0] pkt_count;
  int tests = 0, fails = 0;
  int xfers = 0, rng_pulses = 0;
  logic [7:0] last_x = 0, last_y = 0;
  logic [3:0] last_c = 0;
  logic last_clr = 0;
  spi_pixel_rx_if #(.COLOR_W(4)) wr ();
  spi_pixel_rx dut (
    .clk_hf(clk), .reset(reset), .sck(sck), .sdi(sdi), .cs(cs), .wr(wr),
    .err_range(err_range), .err_overflow(err_overflow), .pkt_count(pkt_count)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (!reset && wr.wr_valid && wr.wr_ready) begin
      xfers++;
      last_x = wr.wr_x;
      last_y = wr.wr_y;
      last_c = wr.wr_color;
      last_clr = wr.wr_clear;
    end
    if (err_range) rng_pulses++;
  end
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      sdi = b[i];
      #50 sck = 1;
      #50 sck = 0;
    end
  endtask
  task automatic send_pkt(input logic [7:0] x, input logic [7:0] y, input logic [7:0] c);
    send_bits(x, 8);
    send_bits(y, 8);
    send_bits(c, 8);
  endtask
  task automatic frame_start();
    cs = 1;
    #60;
  endtask
  task automatic frame_end();
    #50 cs = 0;
    repeat (12) @(posedge clk);
    #1;
  endtask
  initial begin
    wr.wr_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 16'(wr.wr_valid), 0);
    chk("rst_x", 16'(wr.wr_x), 0);
    chk("rst_y", 16'(wr.wr_y), 0);
    chk("rst_color", 16'(wr.wr_color), 0);
    chk("rst_clear", 16'(wr.wr_clear), 0);
    chk("rst_err_range", 16'(err_range), 0);
    chk("rst_err_ovf", 16'(err_overflow), 0);
    chk("rst_pkt_count", pkt_count, 0);
    reset = 0;
    repeat (2) @(posedge clk);
    frame_start();
    send_pkt(8'h05, 8'h0A, 8'h03);
    frame_end();
    chk("p1_xfers", 16'(xfers), 1);
    chk("p1_x", 16'(last_x), 5);
    chk("p1_y", 16'(last_y), 10);
    chk("p1_color", 16'(last_c), 3);
    chk("p1_clear", 16'(last_clr), 0);
    chk("p1_no_range", 16'(rng_pulses), 0);
    chk("p1_valid_low", 16'(wr.wr_valid), 0);
    chk("p1_pkt_count", pkt_count, 16'(PKT_EN));
    frame_start();
    send_pkt(8'hA0, 8'h00, 8'h01);
    frame_end();
    chk("range_no_xfer", 16'(xfers), 1);
    chk("range_pulse_1cyc", 16'(rng_pulses), 1);
    frame_start();
    send_pkt(8'h9F, 8'h77, 8'h0F);
    frame_end();
    chk("edge_xfers", 16'(xfers), 2);
    chk("edge_x", 16'(last_x), 159);
    chk("edge_y", 16'(last_y), 119);
    chk("edge_color", 16'(last_c), 15);
    frame_start();
    send_pkt(8'hFF, 8'hFF, 8'h82);
    frame_end();
    chk("clr_xfers", 16'(xfers), 3);
    chk("clr_flag", 16'(last_clr), 1);
    chk("clr_color", 16'(last_c), 2);
    chk("clr_no_range", 16'(rng_pulses), 1);
    wr.wr_ready = 0;
    frame_start();
    send_pkt(8'h01, 8'h01, 8'h01);
    send_pkt(8'h02, 8'h02, 8'h02);
    frame_end();
    chk("ovf_valid", 16'(wr.wr_valid), 1);
    chk("ovf_x", 16'(wr.wr_x), 1);
    chk("ovf_y", 16'(wr.wr_y), 1);
    chk("ovf_color", 16'(wr.wr_color), 1);
    chk("ovf_sticky", 16'(err_overflow), 1);
    chk("ovf_no_xfer", 16'(xfers), 3);
    @(negedge clk);
    wr.wr_ready = 1;
    repeat (4) @(posedge clk);
    #1;
    chk("ovf_xfers", 16'(xfers), 4);
    chk("ovf_rel_x", 16'(last_x), 1);
    chk("ovf_rel_color", 16'(last_c), 1);
    chk("ovf_pkt_count", pkt_count, 16'(4 * PKT_EN));
    frame_start();
    send_bits(8'hAA, 8);
    send_bits(8'h55, 5);
    frame_end();
    frame_start();
    send_pkt(8'h07, 8'h08, 8'h09);
    frame_end();
    chk("abort_xfers", 16'(xfers), 5);
    chk("abort_x", 16'(last_x), 7);
    chk("abort_y", 16'(last_y), 8);
    chk("abort_color", 16'(last_c), 9);
    chk("abort_ovf_held", 16'(err_overflow), 1);
    wr.wr_ready = 0;
    frame_start();
    send_pkt(8'h03, 8'h04, 8'h05);
    send_bits(8'hF0, 3);
    #20;
    chk("pre_rst_valid", 16'(wr.wr_valid), 1);
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    chk("mid_rst_valid", 16'(wr.wr_valid), 0);
    chk("mid_rst_x", 16'(wr.wr_x), 0);
    chk("mid_rst_y", 16'(wr.wr_y), 0);
    chk("mid_rst_color", 16'(wr.wr_color), 0);
    chk("mid_rst_ovf", 16'(err_overflow), 0);
    chk("mid_rst_pkt_count", pkt_count, 0);
    cs = 0;
    reset = 0;
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/spi_pixel_rx.md
Name: spi_pixel_rx

Overview:
- MCU-facing receive stage directly upstream of the VGA framebuffer/display path in the Pictionary top level.
- Oversamples the raw SPI pins (sck, sdi, cs) in the clk_hf domain and deserializes 3-byte draw packets.
- Range-checks each packet and presents it to the framebuffer writer over a valid/ready handshake.
- Reports dropped packets through error outputs.

Parameters:
- X_MAX, 160, number of valid columns; x must be < X_MAX.
- Y_MAX, 120, number of valid rows; y must be < Y_MAX.
- COLOR_W, 4, colour index width; equals the low COLOR_W bits of byte 2 (COLOR_W ≤ 7).
- SYNC_STAGES, 2, flip-flop depth of the pin synchronizers (≥ 2).

Ports:
- clk_hf  input  1  system clock (HSOSC, 48 MHz).
- reset  input  1  synchronous, active-high reset.
- sck  input  1  SPI clock from MCU (asynchronous to clk_hf).
- sdi  input  1  SPI data from MCU.
- cs  input  1  SPI chip select, active-high, framing one or more packets.
- wr_valid  output  1  packet held on wr_* outputs.
- wr_ready  input  1  framebuffer writer accepts the packet.
- wr_x  output  8  column.
- wr_y  output  8  row.
- wr_color  output  COLOR_W  colour index.
- wr_clear  output  1  clear-screen command; wr_x and wr_y are don't-care when set.
- err_range  output  1  one-cycle pulse: packet dropped because it was out of range.
- err_overflow  output  1  sticky: a packet was dropped because wr_valid was still high.
- pkt_count  output  16  accepted-packet counter (see Optional Feature).

Behaviour:
- Reset values: wr_valid, wr_x, wr_y, wr_color, wr_clear, err_range, err_overflow and pkt_count are all 0. Bit counter, byte index and FSM return to IDLE.
- Synchronization: sck, sdi and cs each pass through SYNC_STAGES flip-flops.
  - A rising edge of sck is detected when the synchronized sck is 1 and its previous registered value is 0.
  - sdi is delayed identically to sck, so it is sampled coherently.
- SPI mode 0, MSB first. The bench guarantees an sck period ≥ 8 clk_hf cycles and a half-period ≥ 4 cycles.
- FSM states: IDLE, BYTE_X, BYTE_Y, BYTE_C.
  - IDLE → BYTE_X when synchronized cs = 1.
  - Each detected sck rising edge while cs = 1 shifts one bit in. The 3-bit bit counter wraps 7→0 on byte completion.
  - BYTE_X → BYTE_Y on the 8th bit (latch x).
  - BYTE_Y → BYTE_C on the 8th bit (latch y).
  - BYTE_C → BYTE_X on the 8th bit (packet complete). Back-to-back packets within one cs assertion are supported.
  - Synchronized cs = 0 in any state → IDLE; bit counter and partial packet are discarded and no output changes. This also covers a cs deassertion on an exact byte boundary.
- Byte 2 format: bit 7 is the clear flag, bits 6:COLOR_W are ignored, and bits COLOR_W-1:0 are the colour.
- Packet completion, evaluated in the cycle the 24th edge is detected (cycle N):
  - wr_valid = 1 and not accepting this cycle: drop the packet, set err_overflow = 1 (sticky until reset).
  - Otherwise, if clear = 0 and (x ≥ X_MAX or y ≥ Y_MAX): drop the packet and pulse err_range for exactly cycle N+1.
  - Otherwise: load wr_* registers and set wr_valid = 1 at cycle N+1.
- Handshake:
  - The transfer happens on a clk_hf edge with wr_valid & wr_ready; wr_valid drops the next cycle unless a new packet loads in that same cycle.
  - Simultaneous accept and completion: accept wins the slot, the new packet loads, and it is not an overflow.
  - wr_x, wr_y, wr_color and wr_clear are stable while wr_valid = 1 and !wr_ready.
- Reset mid-packet or while wr_valid = 1: everything returns to reset values on the next clk_hf edge and the pending packet is lost.

Optional Feature:
- Macro: SPI_PKT_COUNT_EN.
- Defined: pkt_count increments by 1 on each accepted transfer (wr_valid & wr_ready). It wraps 0xFFFF→0x0000 and is cleared by reset.
- Undefined: pkt_count is constant 0 and no counter flops are inferred.

Test Plan:
- Send 0x05, 0x0A, 0x03 in one cs frame with wr_ready = 1 → one wr_valid pulse with x = 5, y = 10, color = 3, clear = 0; err_range stays 0; pkt_count = 1 with the macro defined.
- Send 0xA0, 0x00, 0x01 (x = 160) → no wr_valid, err_range pulses for 1 cycle; then send 0x9F, 0x77, 0x0F → accepted with x = 159, y = 119, color = 15.
- Send 0xFF, 0xFF, 0x82 → wr_valid with wr_clear = 1, color = 2, and no err_range.
- Hold wr_ready = 0 and send two packets back to back (1,1,1) then (2,2,2) → outputs stay at (1,1,1) and err_overflow = 1; raising wr_ready gives a single transfer of (1,1,1).
- Deassert cs after 13 bits, then send 0x07, 0x08, 0x09 → only (7,8,9) is emitted; assert reset mid-byte → all outputs are 0 the next cycle.
